// File: rtl/mmio_router_pkg.sv
// Shared definitions for the MMIO router: port indices, decode-error data and the default region map.
package mmio_router_pkg;

    typedef logic [3:0] port_idx_t;

    localparam port_idx_t PORT_RAM   = 4'd0;
    localparam port_idx_t PORT_VIDEO = 4'd1;
    localparam port_idx_t PORT_KBD   = 4'd2;
    localparam port_idx_t PORT_AES   = 4'd3;
    localparam port_idx_t PORT_SPI   = 4'd4;
    localparam port_idx_t PORT_NONE  = 4'hF;

    localparam logic [31:0] DECERR_DATA = 32'hDEAD_BEEF;

    // Every region maps to RAM, matching the legacy static mux.
    localparam logic [63:0] DEFAULT_REGION_MAP = {16{4'h0}};

endpackage

// File: rtl/mmio_region_decoder.sv
// Combinational region -> slave port lookup; flags entries that name no existing port.
module mmio_region_decoder
    import mmio_router_pkg::*;
#(
    parameter int unsigned                     NUM_PORTS    = 4,
    parameter int unsigned                     DECODE_WIDTH = 4,
    parameter logic [4*(2**DECODE_WIDTH)-1:0]  REGION_MAP   = DEFAULT_REGION_MAP
) (
    input  logic [DECODE_WIDTH-1:0] i_region,
    output port_idx_t               o_tgt,
    output logic                    o_unmapped
);

    port_idx_t w_entry;

    assign w_entry    = REGION_MAP[{i_region, 2'b00} +: 4];
    assign o_tgt      = w_entry;
    assign o_unmapped = (w_entry == PORT_NONE) || (w_entry >= 4'(NUM_PORTS));

endmodule

// File: rtl/mmio_router.sv
// CPU-side MMIO router: region decode, valid/ready forwarding and in-order read return.
// Define MMIO_ROUTER_DECERR_EN to answer unmapped reads with DECERR_DATA and the error flag.
module mmio_router
    import mmio_router_pkg::*;
#(
    parameter int unsigned                     NUM_PORTS       = 4,
    parameter int unsigned                     DECODE_LSB      = 16,
    parameter int unsigned                     DECODE_WIDTH    = 4,
    parameter logic [4*(2**DECODE_WIDTH)-1:0]  REGION_MAP      = DEFAULT_REGION_MAP,
    parameter int unsigned                     MAX_OUTSTANDING = 4
) (
    input  logic                      clk_cpu_in,
    input  logic                      rst_n_in,
    input  logic                      cpu_req_valid_in,
    output logic                      cpu_req_ready_out,
    input  logic [31:0]               cpu_addr_in,
    input  logic [31:0]               cpu_data_in,
    input  logic [3:0]                cpu_we_in,
    output logic                      cpu_rsp_valid_out,
    output logic [31:0]               cpu_rsp_data_out,
    output logic                      cpu_rsp_err_out,
    output logic [NUM_PORTS-1:0]      slv_req_valid_out,
    input  logic [NUM_PORTS-1:0]      slv_req_ready_in,
    output logic [31:0]               slv_addr_out,
    output logic [31:0]               slv_data_out,
    output logic [3:0]                slv_we_out,
    input  logic [NUM_PORTS-1:0]      slv_rsp_valid_in,
    input  logic [32*NUM_PORTS-1:0]   slv_rsp_data_in
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [CNT_W-1:0] r_count;
    port_idx_t        r_cur_port;
    logic             r_err_pend;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_err;

    port_idx_t        w_tgt_raw;
    port_idx_t        w_port;
    logic             w_unmapped;
    logic             w_route;
    logic             w_is_read;
    logic             w_stall;
    logic             w_slv_ready;
    logic             w_rsp_hit;
    logic [31:0]      w_rsp_sel;
    logic             w_accept;
    logic             w_rd_fwd;
    logic             w_capture;

    mmio_region_decoder #(
        .NUM_PORTS    (NUM_PORTS),
        .DECODE_WIDTH (DECODE_WIDTH),
        .REGION_MAP   (REGION_MAP)
    ) u_decoder (
        .i_region   (cpu_addr_in[DECODE_LSB +: DECODE_WIDTH]),
        .o_tgt      (w_tgt_raw),
        .o_unmapped (w_unmapped)
    );

`ifdef MMIO_ROUTER_DECERR_EN
    // Unmapped requests are absorbed by the router and never reach a slave.
    assign w_port  = w_tgt_raw;
    assign w_route = ~w_unmapped;
`else
    assign w_port  = w_unmapped ? PORT_RAM : w_tgt_raw;
    assign w_route = 1'b1;
`endif

    assign w_is_read = (cpu_we_in == 4'b0000);

    // Reads may only join an in-flight burst to the same port, which keeps returns in order.
    always_comb begin
        w_stall = r_err_pend;
        if (w_is_read) begin
            if (r_count == CNT_W'(MAX_OUTSTANDING)) w_stall = 1'b1;
            if ((r_count != '0) && ((w_port != r_cur_port) || !w_route)) w_stall = 1'b1;
        end
    end

    always_comb begin
        w_slv_ready = 1'b0;
        w_rsp_hit   = 1'b0;
        w_rsp_sel   = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_port == 4'(p)) w_slv_ready = slv_req_ready_in[p];
            if (r_cur_port == 4'(p)) begin
                w_rsp_hit = slv_rsp_valid_in[p];
                w_rsp_sel = slv_rsp_data_in[32*p +: 32];
            end
        end
    end

    always_comb begin
        slv_req_valid_out = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            slv_req_valid_out[p] = rst_n_in & cpu_req_valid_in & ~w_stall & w_route & (w_port == 4'(p));
        end
    end

    assign cpu_req_ready_out = rst_n_in & ~w_stall & (w_route ? w_slv_ready : 1'b1);
    assign slv_addr_out      = cpu_addr_in;
    assign slv_data_out      = cpu_data_in;
    assign slv_we_out        = cpu_we_in;

    assign w_accept  = cpu_req_valid_in & cpu_req_ready_out;
    assign w_rd_fwd  = w_accept & w_is_read & w_route;
    assign w_capture = (r_count != '0) & w_rsp_hit;

    always_ff @(posedge clk_cpu_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count     <= '0;
            r_cur_port  <= PORT_RAM;
            r_err_pend  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_err_pend  <= 1'b0;
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_rsp_sel;
            end
            case ({w_rd_fwd, w_capture})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_rd_fwd) r_cur_port <= w_port;
`ifdef MMIO_ROUTER_DECERR_EN
            // Only possible with nothing in flight, so it cannot collide with a slave capture.
            if (w_accept && w_is_read && !w_route) begin
                r_err_pend  <= 1'b1;
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= DECERR_DATA;
                r_rsp_err   <= 1'b1;
            end
`endif
        end
    end

    assign cpu_rsp_valid_out = r_rsp_valid;
    assign cpu_rsp_data_out  = r_rsp_data;
    assign cpu_rsp_err_out   = r_rsp_err;

endmodule

// File: tb/tb_mmio_router.sv
// Self-checking bench for mmio_router: queue-based reference model, directed scenarios and random traffic.
// Honours MMIO_ROUTER_DECERR_EN when the design is built with it.
module tb_mmio_router;
    import mmio_router_pkg::*;

    localparam int NP   = 4;
    localparam int MAXO = 4;
    // Regions 15..0: 5 names a nonexistent port, 6 and 11 are explicitly unmapped.
    localparam logic [63:0] MAP = {4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'h3, 4'h2, 4'h1,
                                   4'h0, 4'hF, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0};
    int region_port [16] = '{0, 0, 1, 2, 3, 4, 15, 0, 1, 2, 3, 15, 0, 1, 2, 3};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_valid;
    logic              cpu_ready;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_we;
    logic              rsp_v;
    logic [31:0]       rsp_d;
    logic              rsp_e;
    logic [NP-1:0]     sv;
    logic [NP-1:0]     sready;
    logic [31:0]       saddr;
    logic [31:0]       sdata;
    logic [3:0]        swe;
    logic [NP-1:0]     srv;
    logic [32*NP-1:0]  srd;

    mmio_router #(
        .NUM_PORTS       (NP),
        .DECODE_LSB      (16),
        .DECODE_WIDTH    (4),
        .REGION_MAP      (MAP),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_cpu_in        (clk),
        .rst_n_in          (rst_n),
        .cpu_req_valid_in  (cpu_valid),
        .cpu_req_ready_out (cpu_ready),
        .cpu_addr_in       (cpu_addr),
        .cpu_data_in       (cpu_wdata),
        .cpu_we_in         (cpu_we),
        .cpu_rsp_valid_out (rsp_v),
        .cpu_rsp_data_out  (rsp_d),
        .cpu_rsp_err_out   (rsp_e),
        .slv_req_valid_out (sv),
        .slv_req_ready_in  (sready),
        .slv_addr_out      (saddr),
        .slv_data_out      (sdata),
        .slv_we_out        (swe),
        .slv_rsp_valid_in  (srv),
        .slv_rsp_data_in   (srd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } sreq_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          outq [$];
    sreq_t       sq [$];
    bit          exp_rsp_v = 0;
    logic [31:0] exp_rsp_d = '0;
    bit          exp_rsp_e = 0;
    bit          err_pend = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    bit          force_en = 0;
    logic [31:0] force_d = '0;
    int          exp_rsp_total = 0;

    bit          dut_acc;
    int          acc_cyc;
    int          last_rsp_cyc = -100;
    logic [31:0] last_rsp_data = '0;
    logic        last_rsp_err = 1'b0;
    int          rsp_cnt = 0;
    logic [NP-1:0] last_sv = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model and slaves past the rising edge.
    task automatic cycle();
        int          p;
        int          eff;
        bit          unm;
        bit          routed;
        bit          is_rd;
        bit          allowed;
        bit          exp_rdy;
        bit          acc;
        bit          cap;
        logic [NP-1:0] exp_sv;
        sreq_t       sr;
        sreq_t       sn;
        bit          n_rsp_v;
        logic [31:0] n_rsp_d;
        bit          n_rsp_e;
        bit          n_err_pend;

        @(negedge clk);
        p   = region_port[cpu_addr[19:16]];
        unm = (p == 15) || (p >= NP);
`ifdef MMIO_ROUTER_DECERR_EN
        eff    = p;
        routed = !unm;
`else
        eff    = unm ? 0 : p;
        routed = 1'b1;
`endif
        is_rd = (cpu_we == 4'b0000);
        if (is_rd)
            allowed = !err_pend && (outq.size() < MAXO) &&
                      ((outq.size() == 0) || (routed && outq[0] == eff));
        else
            allowed = !err_pend;
        exp_rdy = rst_n && allowed && (routed ? sready[eff] : 1'b1);
        exp_sv  = '0;
        if (rst_n && cpu_valid && allowed && routed) exp_sv[eff] = 1'b1;

        chk("req_ready", {31'b0, cpu_ready}, {31'b0, exp_rdy});
        chk("slv_req_valid", {28'b0, sv}, {28'b0, exp_sv});
        chk("slv_addr", saddr, cpu_addr);
        chk("slv_data", sdata, cpu_wdata);
        chk("slv_we", {28'b0, swe}, {28'b0, cpu_we});
        chk("rsp_valid", {31'b0, rsp_v}, {31'b0, exp_rsp_v});
        if (exp_rsp_v || !rst_n) begin
            chk("rsp_data", rsp_d, exp_rsp_d);
            chk("rsp_err", {31'b0, rsp_e}, {31'b0, exp_rsp_e});
        end

        dut_acc = cpu_valid && cpu_ready;
        if (dut_acc) begin
            acc_cyc = cyc;
            last_sv = sv;
        end
        if (rsp_v) begin
            rsp_cnt++;
            last_rsp_cyc  = cyc;
            last_rsp_data = rsp_d;
            last_rsp_err  = rsp_e;
        end

        cap = 1'b0;
        if (rst_n && srv != '0 && sq.size() > 0) begin
            sr = sq.pop_front();
            if (outq.size() > 0) begin
                chk("slv_rsp_port", sr.port, outq[0]);
                cap = 1'b1;
            end
        end

        acc        = cpu_valid && exp_rdy;
        n_rsp_v    = 1'b0;
        n_rsp_d    = exp_rsp_d;
        n_rsp_e    = 1'b0;
        n_err_pend = 1'b0;
        if (cap) begin
            void'(outq.pop_front());
            n_rsp_v = 1'b1;
            n_rsp_d = sr.data;
        end
        if (acc && is_rd) begin
            if (routed) begin
                outq.push_back(eff);
                sn.port = eff;
                sn.data = force_en ? force_d : $urandom;
                sn.due  = cyc + 1 + $urandom_range(lat_hi, lat_lo);
                sq.push_back(sn);
            end else begin
                n_rsp_v    = 1'b1;
                n_rsp_d    = DECERR_DATA;
                n_rsp_e    = 1'b1;
                n_err_pend = 1'b1;
            end
        end
        if (n_rsp_v) exp_rsp_total++;

        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            exp_rsp_v = n_rsp_v;
            exp_rsp_d = n_rsp_d;
            exp_rsp_e = n_rsp_e;
            err_pend  = n_err_pend;
        end
        srv = '0;
        for (int i = 0; i < NP; i++) srd[32*i +: 32] = $urandom;
        if (rst_n && sq.size() > 0 && sq[0].due <= cyc) begin
            srv[sq[0].port] = 1'b1;
            srd[32*sq[0].port +: 32] = sq[0].data;
        end
    endtask

    task automatic idle(input int n);
        cpu_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] w, output int stalls, output int ac);
        stalls    = 0;
        ac        = -1;
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_we    = w;
        cpu_wdata = $urandom;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (dut_acc) begin
                ac = acc_cyc;
                break;
            end
            stalls++;
        end
        cpu_valid = 1'b0;
        chk("req_accepted", {31'b0, (ac >= 0)}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int ac;
        int base;

        rst_n     = 1'b0;
        cpu_valid = 1'b1;
        cpu_addr  = 32'h0002_0000;
        cpu_wdata = '0;
        cpu_we    = 4'b0000;
        sready    = '1;
        srv       = '0;
        srd       = '0;
        #3;
        chk("reset_ready", {31'b0, cpu_ready}, 32'd0);
        chk("reset_slv_valid", {28'b0, sv}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_v}, 32'd0);
        chk("reset_rsp_data", rsp_d, 32'd0);
        chk("reset_rsp_err", {31'b0, rsp_e}, 32'd0);
        cpu_valid = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        idle(2);

        // Video read, slave answers three cycles after acceptance.
        lat_lo = 2; lat_hi = 2; force_en = 1'b1; force_d = 32'h1234_5678;
        base = rsp_cnt;
        req(32'h0002_0010, 4'b0000, st, ac);
        idle(8);
        chk("t1_stall", st, 0);
        chk("t1_latency", last_rsp_cyc - ac, 4);
        chk("t1_data", last_rsp_data, 32'h1234_5678);
        chk("t1_err", {31'b0, last_rsp_err}, 32'd0);
        chk("t1_rsp_count", rsp_cnt - base, 1);
        force_en = 1'b0;

        // Outstanding-limit stall on port 0.
        lat_lo = 5; lat_hi = 5;
        base = rsp_cnt;
        for (int i = 0; i < 4; i++) begin
            req(32'h0000_0100 + 32'(4 * i), 4'b0000, st, ac);
            chk("t2_burst_stall", st, 0);
        end
        req(32'h0000_0200, 4'b0000, st, ac);
        chk("t2_fifth_stall", st, 3);
        idle(14);
        chk("t2_rsp_count", rsp_cnt - base, 5);

        // Port switch waits for the port 0 read to drain.
        lat_lo = 3; lat_hi = 3;
        req(32'h0000_0300, 4'b0000, st, ac);
        req(32'h0003_0000, 4'b0000, st, ac);
        chk("t3_switch_stall", st, 4);
        idle(8);

        // Write held by a busy AES port for two cycles.
        base = rsp_cnt;
        sready[3] = 1'b0;
        cpu_valid = 1'b1;
        cpu_addr  = 32'h0004_0008;
        cpu_we    = 4'b0011;
        cpu_wdata = 32'hCAFE_0001;
        cycle();
        chk("t4_hold1", {31'b0, dut_acc}, 32'd0);
        cycle();
        chk("t4_hold2", {31'b0, dut_acc}, 32'd0);
        sready[3] = 1'b1;
        cycle();
        chk("t4_accept", {31'b0, dut_acc}, 32'd1);
        chk("t4_slv_valid", {28'b0, last_sv}, 32'h8);
        idle(4);
        chk("t4_no_rsp", rsp_cnt - base, 0);

        // Read of an unmapped region.
        lat_lo = 1; lat_hi = 1;
        req(32'h0006_0000, 4'b0000, st, ac);
`ifdef MMIO_ROUTER_DECERR_EN
        chk("t5_slv_valid", {28'b0, last_sv}, 32'd0);
        idle(3);
        chk("t5_latency", last_rsp_cyc - ac, 1);
        chk("t5_data", last_rsp_data, 32'hDEAD_BEEF);
        chk("t5_err", {31'b0, last_rsp_err}, 32'd1);
`else
        chk("t5_slv_valid", {28'b0, last_sv}, 32'h1);
        idle(4);
        chk("t5_err", {31'b0, last_rsp_err}, 32'd0);
`endif

        // Reset with two reads in flight, then a stale slave response.
        lat_lo = 6; lat_hi = 6;
        req(32'h0000_0400, 4'b0000, st, ac);
        req(32'h0000_0404, 4'b0000, st, ac);
        cpu_valid = 1'b1;
        cpu_addr  = 32'h0000_0408;
        cpu_we    = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ready", {31'b0, cpu_ready}, 32'd0);
        chk("t6_slv_valid", {28'b0, sv}, 32'd0);
        chk("t6_rsp_valid", {31'b0, rsp_v}, 32'd0);
        chk("t6_rsp_data", rsp_d, 32'd0);
        chk("t6_rsp_err", {31'b0, rsp_e}, 32'd0);
        cpu_valid = 1'b0;
        outq.delete();
        exp_rsp_v = 1'b0;
        exp_rsp_d = '0;
        exp_rsp_e = 1'b0;
        err_pend  = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        base = rsp_cnt;
        idle(12);
        chk("t6_stale_ignored", rsp_cnt - base, 0);

        // Random traffic.
        lat_lo = 0; lat_hi = 4;
        base = rsp_cnt;
        exp_rsp_total = 0;
        for (int i = 0; i < 3000; i++) begin
            cpu_valid = ($urandom_range(3, 0) != 0);
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            cpu_we    = ($urandom_range(1, 0) == 0) ? 4'b0000 : 4'($urandom_range(15, 1));
            sready    = NP'($urandom);
            cycle();
        end
        sready = '1;
        idle(20);
        chk("rand_rsp_total", rsp_cnt - base, exp_rsp_total);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
